// File: rtl/encode_hex_to_ascii.sv
// encode_hex_to_ascii: prints a NIBBLES-digit hex value as ASCII characters,
// most significant digit first, over a toggle-handshake link to a UART
// transmitter. Requests and acknowledges are level toggles; each is buffered
// once and edge-detected against a stored previous value.
// Optional feature: define APPEND_CRLF_EN to append 0x0D, 0x0A to each frame.
module encode_hex_to_ascii #(
  parameter int NIBBLES   = 4,
  parameter int UPPERCASE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*NIBBLES-1:0]   hex_data,
  input  logic                   input_strobe,
  input  logic                   tx_done,
  output logic [7:0]             ascii_data,
  output logic                   tx_strobe,
  output logic                   busy,
  output logic                   send_complete_toggle_signal,
  output logic                   overrun
);

  localparam int DATA_W = 4 * NIBBLES;
`ifdef APPEND_CRLF_EN
  localparam int CHARS = NIBBLES + 2;
`else
  localparam int CHARS = NIBBLES;
`endif
  localparam logic [3:0] LAST_IDX = 4'(CHARS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_ACK,
    DONE
  } state_t;

  state_t            state, state_next;
  logic              in_buf, in_prev;
  logic              ack_buf, ack_prev;
  logic              req_edge, ack_edge;
  logic [DATA_W-1:0] data_q, data_next;
  logic [3:0]        idx, idx_next;
  logic [7:0]        ascii_next;
  logic              tx_strobe_next;
  logic              busy_next;
  logic              complete_next;
  logic              overrun_next;

  // One hex digit to its ASCII code; letters follow the UPPERCASE setting.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end else if (UPPERCASE != 0) begin
      return 8'h37 + {4'h0, n};
    end else begin
      return 8'h57 + {4'h0, n};
    end
  endfunction

  // Character at position i of the frame: digits MSB first, then CR/LF when enabled.
  function automatic logic [7:0] char_at(input logic [DATA_W-1:0] d, input logic [3:0] i);
    logic [DATA_W-1:0] sh;
`ifdef APPEND_CRLF_EN
    if (i == 4'(NIBBLES)) begin
      return 8'h0D;
    end
    if (i == 4'(NIBBLES + 1)) begin
      return 8'h0A;
    end
`endif
    sh = d >> (4 * (NIBBLES - 1 - int'(i)));
    return hex_char(sh[3:0]);
  endfunction

  // Strobe buffers and previous-value registers for both toggle inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_buf   <= 1'b0;
      in_prev  <= 1'b0;
      ack_buf  <= 1'b0;
      ack_prev <= 1'b0;
    end else begin
      in_buf   <= input_strobe;
      in_prev  <= in_buf;
      ack_buf  <= tx_done;
      ack_prev <= ack_buf;
    end
  end

  // Previous values always track, so edges arriving in the wrong state are absorbed.
  assign req_edge = in_buf ^ in_prev;
  assign ack_edge = ack_buf ^ ack_prev;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state                       <= IDLE;
      idx                         <= 4'd0;
      ascii_data                  <= 8'h00;
      tx_strobe                   <= 1'b0;
      busy                        <= 1'b0;
      send_complete_toggle_signal <= 1'b0;
      overrun                     <= 1'b0;
    end else begin
      state                       <= state_next;
      idx                         <= idx_next;
      ascii_data                  <= ascii_next;
      tx_strobe                   <= tx_strobe_next;
      busy                        <= busy_next;
      send_complete_toggle_signal <= complete_next;
      overrun                     <= overrun_next;
    end
  end

  // Frame data latch; only ever read after a request has loaded it.
  always_ff @(posedge clk) begin
    data_q <= data_next;
  end

  // Next-state and output logic; any request edge outside IDLE is dropped as an overrun.
  always_comb begin
    state_next     = state;
    idx_next       = idx;
    data_next      = data_q;
    ascii_next     = ascii_data;
    tx_strobe_next = tx_strobe;
    busy_next      = busy;
    complete_next  = send_complete_toggle_signal;
    overrun_next   = req_edge && (state != IDLE);
    case (state)
      IDLE: begin
        if (req_edge) begin
          data_next  = hex_data;
          idx_next   = 4'd0;
          busy_next  = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        state_next = SEND;
      end
      SEND: begin
        ascii_next     = char_at(data_q, idx);
        tx_strobe_next = ~tx_strobe;
        state_next     = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_edge) begin
          if (idx == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next   = idx + 4'd1;
            state_next = SEND;
          end
        end
      end
      DONE: begin
        complete_next = ~send_complete_toggle_signal;
        busy_next     = 1'b0;
        state_next    = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_encode_hex_to_ascii.sv
// Testbench for encode_hex_to_ascii: an uppercase and a lowercase instance
// share stimulus; a scoreboard queue per instance holds expected characters.
// Honours APPEND_CRLF_EN the same way as the design.
module tb_encode_hex_to_ascii;

  localparam int NIB = 4;
`ifdef APPEND_CRLF_EN
  localparam int NCH = NIB + 2;
`else
  localparam int NCH = NIB;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [4*NIB-1:0] hex_data;
  logic             input_strobe;
  logic             tx_done;

  logic [7:0] ascii_u, ascii_l;
  logic       txs_u, txs_l, busy_u, busy_l, cmp_u, cmp_l, ovr_u, ovr_l;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;

  logic [7:0] exp_u[$];
  logic [7:0] exp_l[$];
  logic [7:0] last_u = 8'h00;
  logic [7:0] last_l = 8'h00;
  int   n_tx_u = 0, n_tx_l = 0, n_cmp_u = 0, n_cmp_l = 0, n_ovr_u = 0, n_ovr_l = 0;
  logic txs_u_q = 1'b0, txs_l_q = 1'b0, cmp_u_q = 1'b0, cmp_l_q = 1'b0;
  int   t_req = 0, t_ack = 0;
  bit   first_pending = 1'b0;
  bit   ack_en = 1'b1;
  int   ack_delay = 5;
  int   epoch = 0;
  logic ack_prev = 1'b0;

  string hex_up = "0123456789ABCDEF";
  string hex_lo = "0123456789abcdef";

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  encode_hex_to_ascii #(.NIBBLES(NIB), .UPPERCASE(1)) dut_u (
    .clk                         (clk),
    .rst                         (rst),
    .hex_data                    (hex_data),
    .input_strobe                (input_strobe),
    .tx_done                     (tx_done),
    .ascii_data                  (ascii_u),
    .tx_strobe                   (txs_u),
    .busy                        (busy_u),
    .send_complete_toggle_signal (cmp_u),
    .overrun                     (ovr_u)
  );

  encode_hex_to_ascii #(.NIBBLES(NIB), .UPPERCASE(0)) dut_l (
    .clk                         (clk),
    .rst                         (rst),
    .hex_data                    (hex_data),
    .input_strobe                (input_strobe),
    .tx_done                     (tx_done),
    .ascii_data                  (ascii_l),
    .tx_strobe                   (txs_l),
    .busy                        (busy_l),
    .send_complete_toggle_signal (cmp_l),
    .overrun                     (ovr_l)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [4*NIB-1:0] v);
    logic [3:0] n;
    for (int i = 0; i < NIB; i++) begin
      n = v[4*(NIB-1-i) +: 4];
      exp_u.push_back(hex_up[int'(n)]);
      exp_l.push_back(hex_lo[int'(n)]);
    end
`ifdef APPEND_CRLF_EN
    exp_u.push_back(8'h0D);
    exp_u.push_back(8'h0A);
    exp_l.push_back(8'h0D);
    exp_l.push_back(8'h0A);
`endif
  endtask

  task automatic do_ack();
    tx_done = ~tx_done;
    t_ack = cyc + 1;
  endtask

  task automatic do_req(input logic [4*NIB-1:0] v, input bit accept);
    hex_data = v;
    input_strobe = ~input_strobe;
    if (accept) begin
      push_frame(v);
      t_req = cyc + 1;
      first_pending = 1'b1;
    end
  endtask

  task automatic start_frame(input logic [4*NIB-1:0] v);
    do_req(v, 1'b1);
    @(negedge clk);
    chk("busy_edge_k", busy_u, 0);
    @(negedge clk);
    chk("busy_edge_k1_u", busy_u, 1);
    chk("busy_edge_k1_l", busy_l, 1);
  endtask

  task automatic wait_tx(input int target, input string tag);
    for (int i = 0; i < 200 && n_tx_u < target; i++) @(negedge clk);
    if (n_tx_u < target) chk({tag, "_timeout"}, n_tx_u, target);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy_u && !busy_l && exp_u.size() == 0 && exp_l.size() == 0) break;
    end
    chk({tag, "_left_u"}, exp_u.size(), 0);
    chk({tag, "_left_l"}, exp_l.size(), 0);
    chk({tag, "_busy_u"}, busy_u, 0);
    chk({tag, "_busy_l"}, busy_l, 0);
    chk({tag, "_hold_u"}, ascii_u, last_u);
    chk({tag, "_hold_l"}, ascii_l, last_l);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ascii_u"}, ascii_u, 0);
    chk({tag, "_ascii_l"}, ascii_l, 0);
    chk({tag, "_txs_u"}, txs_u, 0);
    chk({tag, "_txs_l"}, txs_l, 0);
    chk({tag, "_busy_u"}, busy_u, 0);
    chk({tag, "_busy_l"}, busy_l, 0);
    chk({tag, "_cmp_u"}, cmp_u, 0);
    chk({tag, "_cmp_l"}, cmp_l, 0);
    chk({tag, "_ovr_u"}, ovr_u, 0);
    chk({tag, "_ovr_l"}, ovr_l, 0);
  endtask

  // Scoreboard monitor: pops an expected character on every tx_strobe change.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (txs_u != txs_u_q) begin
        n_tx_u++;
        if (exp_u.size() == 0) chk("char_u_extra", exp_u.size(), 1);
        else begin
          last_u = exp_u.pop_front();
          chk("char_u", ascii_u, last_u);
        end
        if (first_pending) begin
          chk("lat_req", cyc, t_req + 3);
          first_pending = 1'b0;
        end else begin
          chk("lat_ack", cyc, t_ack + 2);
        end
      end
      if (txs_l != txs_l_q) begin
        n_tx_l++;
        if (exp_l.size() == 0) chk("char_l_extra", exp_l.size(), 1);
        else begin
          last_l = exp_l.pop_front();
          chk("char_l", ascii_l, last_l);
        end
      end
      if (cmp_u != cmp_u_q) n_cmp_u++;
      if (cmp_l != cmp_l_q) n_cmp_l++;
      if (ovr_u) n_ovr_u++;
      if (ovr_l) n_ovr_l++;
    end
    txs_u_q = txs_u;
    txs_l_q = txs_l;
    cmp_u_q = cmp_u;
    cmp_l_q = cmp_l;
  end

  // Downstream transmitter model: acknowledges each character after ack_delay cycles.
  initial forever begin
    int ep;
    @(negedge clk);
    if (rst && txs_u != ack_prev) begin
      ack_prev = txs_u;
      if (ack_en) begin
        ep = epoch;
        for (int i = 0; i < ack_delay; i++) @(negedge clk);
        if (rst && ep == epoch) do_ack();
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got cycle %0d, want finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b, c, cl, o, ol;
    logic [4*NIB-1:0] rv;
    rst = 1'b0;
    hex_data = '0;
    input_strobe = 1'b0;
    tx_done = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst_init");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // stray acknowledge while idle is absorbed
    tx_done = ~tx_done;
    repeat (6) @(negedge clk);
    chk("stray_ack_busy", busy_u, 0);
    chk("stray_ack_ntx", n_tx_u, 0);

    // 0x1A2F, slow acknowledge
    b = n_tx_u; c = n_cmp_u; cl = n_cmp_l;
    start_frame(16'h1A2F);
    wait_idle("f1a2f");
    chk("f1a2f_ntx", n_tx_u - b, NCH);
    chk("f1a2f_cmp_u", n_cmp_u - c, 1);
    chk("f1a2f_cmp_l", n_cmp_l - cl, 1);

    // 0xBEEF exercises letters in both cases
    b = n_tx_u; c = n_cmp_u;
    start_frame(16'hBEEF);
    wait_idle("fbeef");
    chk("fbeef_ntx", n_tx_u - b, NCH);
    chk("fbeef_cmp", n_cmp_u - c, 1);

    // 0x0009 with immediate acknowledge (latency path)
    ack_delay = 0;
    b = n_tx_u; c = n_cmp_u;
    start_frame(16'h0009);
    wait_idle("f0009");
    chk("f0009_ntx", n_tx_u - b, NCH);
    chk("f0009_cmp", n_cmp_u - c, 1);

    // second request during a frame is dropped
    ack_delay = 5;
    b = n_tx_u; c = n_cmp_u; o = n_ovr_u; ol = n_ovr_l;
    start_frame(16'h5C3D);
    wait_tx(b + 1, "ovr");
    do_req(16'hFFFF, 1'b0);
    wait_idle("ovr");
    chk("ovr_pulse_u", n_ovr_u - o, 1);
    chk("ovr_pulse_l", n_ovr_l - ol, 1);
    chk("ovr_cmp", n_cmp_u - c, 1);
    repeat (10) @(negedge clk);
    chk("ovr_no_2nd_busy", busy_u, 0);
    chk("ovr_no_2nd_ntx", n_tx_u - b, NCH);

    // request coinciding with the final acknowledge
    ack_en = 1'b0;
    b = n_tx_u; c = n_cmp_u; o = n_ovr_u;
    start_frame(16'h4D2E);
    for (int k = 1; k < NCH; k++) begin
      wait_tx(b + k, "simul");
      do_ack();
    end
    wait_tx(b + NCH, "simul_last");
    do_ack();
    do_req(16'h0000, 1'b0);
    wait_idle("simul");
    chk("simul_ovr", n_ovr_u - o, 1);
    chk("simul_cmp", n_cmp_u - c, 1);
    repeat (10) @(negedge clk);
    chk("simul_no_2nd_ntx", n_tx_u - b, NCH);
    chk("simul_no_2nd_busy", busy_u, 0);
    ack_en = 1'b1;
    ack_prev = txs_u;

    // reset after the second character aborts the frame
    b = n_tx_u;
    start_frame(16'h1234);
    wait_tx(b + 2, "rstmid");
    rst = 1'b0;
    input_strobe = 1'b0;
    tx_done = 1'b0;
    epoch++;
    ack_prev = 1'b0;
    exp_u.delete();
    exp_l.delete();
    first_pending = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_mid_cmp_after", cmp_u, 0);
    chk("rst_mid_busy_after", busy_u, 0);

    // full frame after the aborted one
    b = n_tx_u; c = n_cmp_u;
    start_frame(16'h7E01);
    wait_idle("f7e01");
    chk("f7e01_ntx", n_tx_u - b, NCH);
    chk("f7e01_cmp", n_cmp_u - c, 1);
    chk("f7e01_cmp_level", cmp_u, 1);

    // a few random frames with random acknowledge delay
    for (int r = 0; r < 3; r++) begin
      rv = 16'($urandom);
      ack_delay = int'($urandom_range(0, 4));
      b = n_tx_u; c = n_cmp_u;
      start_frame(rv);
      wait_idle("frand");
      chk("frand_ntx", n_tx_u - b, NCH);
      chk("frand_cmp", n_cmp_u - c, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
